// File: rtl/ksa_shuffle.sv
// ksa_shuffle: RC4 key-scheduling shuffle engine.
// It responds to the controller's start/finish handshake. For i = 0..255 it
// computes j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] with S[j] in
// the external 256x8 S-memory. The memory has one cycle of read latency.
// Every output comes straight from a register, so nothing combinational
// reaches an output from start or mem_q.
module ksa_shuffle #(
    parameter int KEY_BYTES = 3,
    parameter int KEY_W     = 8 * KEY_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] secret_key,
    input  logic [7:0]       mem_q,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_data,
    output logic             mem_wren,
    output logic             busy,
    output logic             finish
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [KIDX_W-1:0] KIDX_ONE  = KIDX_W'(1);
    localparam logic [KIDX_W-1:0] KIDX_ZERO = KIDX_W'(0);

    // One state per memory step. A full iteration is RD_I..NEXT, which is 7 cycles.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RD_I = 4'd1,
        S_WT_I = 4'd2,
        S_RD_J = 4'd3,
        S_WT_J = 4'd4,
        S_WR_I = 4'd5,
        S_WR_J = 4'd6,
        S_NEXT = 4'd7,
        S_DONE = 4'd8
    } state_t;

    // Selects key byte idx. Byte 0 is the most significant byte of the key.
    // The loop compares idx with each byte number, so no divider is built.
    function automatic logic [7:0] key_byte(input logic [KEY_W-1:0]  key,
                                            input logic [KIDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (idx == KIDX_W'(k)) begin
                b = key[KEY_W-1-8*k -: 8];
            end
        end
        return b;
    endfunction

    state_t            r_state;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [KIDX_W-1:0] r_kidx;
    logic [KEY_W-1:0]  r_key;
    logic [7:0]        r_addr;
    logic [7:0]        r_data;
    logic              r_wren;
    logic              r_busy;
    logic              r_finish;

    logic [7:0]        w_key_byte;
    logic [7:0]        w_j_next;
    logic [7:0]        w_i_next;
    logic [KIDX_W-1:0] w_kidx_next;

    // The key byte for this i, the new j, and the next i and kidx.
    // j uses 8-bit arithmetic and wraps modulo 256.
    always_comb begin
        w_key_byte  = key_byte(r_key, r_kidx);
        w_j_next    = r_j + mem_q + w_key_byte;
        w_i_next    = r_i + 8'd1;
        w_kidx_next = (r_kidx == KIDX_LAST) ? KIDX_ZERO : (r_kidx + KIDX_ONE);
    end

    // Sequencer. Each transition also loads the output registers with the
    // values that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_i      <= 8'h00;
            r_j      <= 8'h00;
            r_si     <= 8'h00;
            r_sj     <= 8'h00;
            r_kidx   <= KIDX_ZERO;
            r_key    <= {KEY_W{1'b0}};
            r_addr   <= 8'h00;
            r_data   <= 8'h00;
            r_wren   <= 1'b0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_data   <= 8'h00;
            r_wren   <= 1'b0;
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_addr <= 8'h00;
                    if (start) begin
                        r_i     <= 8'h00;
                        r_j     <= 8'h00;
                        r_kidx  <= KIDX_ZERO;
                        r_key   <= secret_key;
                        r_busy  <= 1'b1;
                        r_state <= S_RD_I;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RD_I: begin
                    // Keep addr = i for the cycle in which S[i] comes back.
                    r_addr  <= r_i;
                    r_busy  <= 1'b1;
                    r_state <= S_WT_I;
                end
                S_WT_I: begin
                    r_si    <= mem_q;
                    r_j     <= w_j_next;
                    r_addr  <= w_j_next;
                    r_busy  <= 1'b1;
                    r_state <= S_RD_J;
                end
                S_RD_J: begin
                    r_addr  <= r_j;
                    r_busy  <= 1'b1;
                    r_state <= S_WT_J;
                end
                S_WT_J: begin
                    // S[j] goes straight into the data register for the write to i.
                    r_sj    <= mem_q;
                    r_addr  <= r_i;
                    r_data  <= mem_q;
                    r_wren  <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= S_WR_I;
                end
                S_WR_I: begin
                    // When i == j, S[j] was read before either write,
                    // so both writes store the original S[i].
                    r_addr  <= r_j;
                    r_data  <= r_si;
                    r_wren  <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= S_WR_J;
                end
                S_WR_J: begin
                    r_addr  <= r_i;
                    r_busy  <= 1'b1;
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    r_busy <= 1'b1;
                    if (r_i == 8'hFF) begin
                        r_addr   <= 8'h00;
                        r_finish <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_i     <= w_i_next;
                        r_kidx  <= w_kidx_next;
                        r_addr  <= w_i_next;
                        r_state <= S_RD_I;
                    end
                end
                S_DONE: begin
                    // start is ignored here. The engine becomes startable in IDLE.
                    r_addr  <= 8'h00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_addr  <= 8'h00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr = r_addr;
    assign mem_data = r_data;
    assign mem_wren = r_wren;
    assign busy     = r_busy;
    assign finish   = r_finish;

endmodule

// File: doc/ksa_shuffle.md
# ksa_shuffle

Key-scheduling shuffle engine for the RC4 decrypt datapath. It is the responder on the controller's Start/Finish handshake for the shuffle-A phase. Once started, it walks i = 0..255 over the 256×8 S-memory and, for each i, computes j = j + S[i] + key[i mod 3] and swaps S[i] with S[j]. When the walk completes it pulses finish. It drives the S-memory port only while busy; the memory mux selects its port while the controller sits in the shuffle-A wait state.

## Interface
Parameters:
- KEY_BYTES, 3: key length in bytes. Key byte 0 is the MSB byte.
- KEY_W, 24: key width (8·KEY_BYTES).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  one-cycle request from controller; honoured only in IDLE
- secret_key  in  KEY_W  key; latched on accepted start
- mem_q  in  8  S-memory read data
- mem_addr  out  8  S-memory address
- mem_data  out  8  S-memory write data
- mem_wren  out  1  S-memory write enable
- busy  out  1  high in every state except IDLE
- finish  out  1  one-cycle completion pulse

## Operation
- Memory model:
  - Address presented in cycle N is registered at the end of N; mem_q is valid throughout N+1.
  - A write with mem_wren=1 in cycle N commits at the end of N.
- Registers:
  - i[7:0], j[7:0], si[7:0], sj[7:0]
  - kidx (mod-3 counter, 0..KEY_BYTES-1; no divider)
  - key_r
- Key byte: key_r[KEY_W-1-8·kidx -: 8]. kidx=0 selects the MSB byte.
- States and per-cycle actions:
  - IDLE: addr=0, wren=0. On start: i←0, j←0, kidx←0, key_r←secret_key; go to RD_I.
  - RD_I: addr=i; go to WT_I.
  - WT_I: addr=i; si←mem_q; j←j+mem_q+keybyte (mod 256); go to RD_J.
  - RD_J: addr=j (updated j); go to WT_J.
  - WT_J: addr=j; sj←mem_q; go to WR_I.
  - WR_I: addr=i, data=sj, wren=1; go to WR_J.
  - WR_J: addr=j, data=si, wren=1; go to NEXT.
  - NEXT: if i==255 go to DONE. Otherwise i←i+1, kidx←(kidx==2?0:kidx+1), go to RD_I.
  - DONE: finish=1; go to IDLE.
- mem_wren is high only in WR_I and WR_J. mem_data is 0 in all other states.
- Arithmetic is 8-bit with natural wrap. i wraps only by termination; it never reaches 256.
- i==j: the two writes hit the same address with the same value; the final value must equal the original S[i].
- start while busy (any state other than IDLE) is ignored, with no effect on i, j, kidx or key_r.
- secret_key changes after acceptance have no effect on the run in progress.
- rst in any state returns to IDLE at the next edge. The engine does not resume; the controller must restart it.

## Timing
- Reset values: state=IDLE, busy=0, finish=0, mem_wren=0, mem_addr=0, mem_data=0, i=j=si=sj=kidx=0.
- Per-iteration cost is exactly 7 cycles.
- With start high in cycle 0 (IDLE):
  - RD_I for i=0 is cycle 1.
  - Iteration k occupies cycles 7k+1..7k+7.
  - DONE is cycle 1793, and finish is high only in cycle 1793.
  - busy is high in cycles 1..1793 and low from cycle 1794.
- start may be accepted again in cycle 1794 (IDLE). start high in the DONE cycle itself is ignored.
- All outputs are decoded from state and registers. There is no combinational path from start or mem_q to any output.

## Test plan
- **Reset:** hold rst for 2 cycles, including one with start=1 → busy=0, finish=0, mem_wren=0, mem_addr=0; no memory writes.
- **Key 0x000000, S[x]=x:**
  - After iteration 2: S[2]=3, S[3]=2.
  - Full run: final S matches the software KSA model byte-for-byte.
  - finish is exactly one pulse, 1793 cycles after start.
- **Key 0x010203, S[x]=x:**
  - After iteration 0: S[0]=1, S[1]=0, j=1.
  - After iteration 1: S[1]=3, S[3]=0, j=3.
  - Full run matches the model.
- **i==j:** key 0x000000, iteration 0 (j=0) → WR_I and WR_J both address 0 with data 0; S[0] stays 0.
- **Start while busy:** pulse start at cycles 50 and 1793 → no restart. finish still only at cycle 1793. Final S is unchanged versus the clean run.
- **Reset mid-operation:** assert rst in a WR_I cycle (~cycle 300) → IDLE next edge, busy=0, mem_wren=0, no finish. A fresh start then completes in 1793 cycles.
